// File: rtl/add_multiword_seq_if.sv
// Request/response bundle for the multi-word adder sequencer.
interface add_multiword_seq_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned NUM_WORDS = 4
);
  localparam int unsigned TOTAL_W = WORD_SIZE * NUM_WORDS;

  logic               in_valid;
  logic               in_ready;
  logic               cin;
  logic [TOTAL_W-1:0] in0;
  logic [TOTAL_W-1:0] in1;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] sum;
  logic               cout;

  // Requester side: drives operands, consumes the result.
  modport master (
    output in_valid, cin, in0, in1, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Sequencer side.
  modport slave (
    input  in_valid, cin, in0, in1, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/add_multiword_seq.sv
// Multi-precision adder: one WORD_SIZE slice per cycle through a shared adder,
// carry chained slice to slice, result held on a valid/ready handshake.

// Narrow ripple adder shared by every slice of the wide operation.
module add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  // Single full-width add with carry out on the extra bit.
  always_comb begin
    {cout_o, sum_o} = (WIDTH+1)'(a_i) + (WIDTH+1)'(b_i) + (WIDTH+1)'(cin_i);
  end
endmodule

module add_multiword_seq #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  add_multiword_seq_if.slave  bus
);
  localparam int unsigned TOTAL_W = WORD_SIZE * NUM_WORDS;
  localparam int unsigned IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TOTAL_W-1:0]   a_q, a_d;
  logic [TOTAL_W-1:0]   b_q, b_d;
  logic [TOTAL_W-1:0]   sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic                 cout_q, cout_d;

  logic [WORD_SIZE-1:0] slice_a_c;
  logic [WORD_SIZE-1:0] slice_b_c;
  logic [WORD_SIZE-1:0] slice_sum_c;
  logic                 slice_cout_c;
  logic                 last_c;

  // Select the current slice of the latched operands.
  always_comb begin
    slice_a_c = a_q[idx_q*WORD_SIZE +: WORD_SIZE];
    slice_b_c = b_q[idx_q*WORD_SIZE +: WORD_SIZE];
    last_c    = (idx_q == IDX_W'(NUM_WORDS - 1));
  end

  add #(.WIDTH(WORD_SIZE)) u_add (
    .a_i    (slice_a_c),
    .b_i    (slice_b_c),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_c),
    .cout_o (slice_cout_c)
  );

  // Next-state and datapath update for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in0;
          b_d     = bus.in1;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*WORD_SIZE +: WORD_SIZE] = slice_sum_c;
        carry_d = slice_cout_c;
        idx_d   = idx_q + 1'b1;
        if (last_c) begin
          cout_d  = slice_cout_c;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Ready is masked by reset so an operation presented alongside rst is never taken.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_add_multiword_seq.sv
// Bench for add_multiword_seq: cycle-level reference model plus directed and random ops.
module tb_add_multiword_seq;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  add_multiword_seq_if #(.WORD_SIZE(8), .NUM_WORDS(NW)) bus4 ();
  add_multiword_seq_if #(.WORD_SIZE(8), .NUM_WORDS(1))  bus1 ();

  add_multiword_seq #(.WORD_SIZE(8), .NUM_WORDS(NW)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  add_multiword_seq #(.WORD_SIZE(8), .NUM_WORDS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference model: one op in flight, result visible NW+1 cycles after acceptance.
  bit        m_busy = 1'b0;
  int        m_due  = 0;
  logic [32:0] m_exp = '0;
  bit        m_rdy, m_vld;

  always @(negedge clk) begin
    if (chk_en) begin
      m_rdy = !m_busy && !rst;
      m_vld = m_busy && (cyc >= m_due);
      chk("in_ready", bus4.in_ready, m_rdy);
      chk("out_valid", bus4.out_valid, m_vld);
      if (m_vld) begin
        chk("sum", bus4.sum, m_exp[31:0]);
        chk("cout", bus4.cout, m_exp[32]);
      end
      if (rst) begin
        m_busy = 1'b0;
      end else if (m_rdy && bus4.in_valid) begin
        m_busy = 1'b1;
        m_due  = cyc + NW + 1;
        m_exp  = 33'(bus4.in0) + 33'(bus4.in1) + 33'(bus4.cin);
      end else if (m_vld && bus4.out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // One operation on the 4-word DUT with bp cycles of output backpressure.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input int bp, output logic [31:0] s, output logic co, output int lat);
    int n;
    int acc_c;
    s   = '0;
    co  = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    bus4.in0 = a; bus4.in1 = b; bus4.cin = c;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = (bp == 0);
    n = 0;
    @(negedge clk);
    while (!bus4.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus4.in_ready) begin fail_now("accept"); bus4.in_valid = 1'b0; return; end
    acc_c = cyc;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus4.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus4.out_valid) begin fail_now("result"); return; end
    lat = cyc - acc_c;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      bus4.in_valid = 1'($urandom_range(0, 1));
      bus4.in0 = $urandom; bus4.in1 = $urandom;
      bus4.cin = 1'($urandom_range(0, 1));
    end
    if (bp > 0) begin
      @(posedge clk); #1;
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      @(negedge clk);
    end
    s  = bus4.sum;
    co = bus4.cout;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  logic [31:0] s, ra, rb;
  logic        co, rc;
  int          lat, k, n, acc[3];
  logic [32:0] e;
  logic [8:0]  e1;

  initial begin
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.cin = 1'b0; bus4.in0 = '0; bus4.in1 = '0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.cin = 1'b0; bus1.in0 = '0; bus1.in1 = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus4.in_ready, 1'b0);
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_sum", bus4.sum, 32'h0);
    chk("rst_cout", bus4.cout, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus4.in_ready, 1'b1);

    // Full carry ripple through every slice
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, s, co, lat);
    chk("ripple_sum", s, 32'h0000_0000);
    chk("ripple_cout", co, 1'b1);
    chk("ripple_latency", lat, 5);

    // Carry-in into slice 0
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, s, co, lat);
    chk("cin_sum", s, 32'h2345_678A);
    chk("cin_cout", co, 1'b0);

    // Backpressure with ignored input pulses
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 10, s, co, lat);
    chk("bp_sum", s, 32'h0000_0000);
    chk("bp_cout", co, 1'b1);
    @(negedge clk);
    chk("bp_idle_ready", bus4.in_ready, 1'b1);

    // Reset during the second RUN cycle
    @(posedge clk); #1;
    bus4.in0 = 32'hDEAD_BEEF; bus4.in1 = 32'h0123_4567; bus4.cin = 1'b1;
    bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_accept_ready", bus4.in_ready, 1'b1);
    @(posedge clk); #1 bus4.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_sum", bus4.sum, 32'h0);
    chk("mid_rst_cout", bus4.cout, 1'b0);
    chk("mid_rst_ready", bus4.in_ready, 1'b1);
    chk("mid_rst_valid", bus4.out_valid, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0, s, co, lat);
    chk("after_rst_sum", s, 32'h0000_0007);
    chk("after_rst_cout", co, 1'b0);

    // Back-to-back with in_valid held high
    @(posedge clk); #1;
    bus4.out_ready = 1'b1;
    bus4.in0 = $urandom; bus4.in1 = $urandom; bus4.cin = 1'($urandom_range(0, 1));
    bus4.in_valid = 1'b1;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      @(negedge clk); n++;
      if (bus4.in_ready) begin
        acc[k] = cyc; k++;
        @(posedge clk); #1;
        if (k < 3) begin
          bus4.in0 = $urandom; bus4.in1 = $urandom; bus4.cin = 1'($urandom_range(0, 1));
        end else begin
          bus4.in_valid = 1'b0;
        end
      end
    end
    if (k < 3) fail_now("b2b_accept");
    else begin
      chk("b2b_gap01", acc[1] - acc[0], 6);
      chk("b2b_gap12", acc[2] - acc[1], 6);
    end
    repeat (8) @(posedge clk);
    #1 bus4.out_ready = 1'b0;

    // Random operands and backpressure
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (i % 4 == 0) ra = 32'hFFFF_FFFF;
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), s, co, lat);
      e = 33'(ra) + 33'(rb) + 33'(rc);
      chk("rand_sum", s, e[31:0]);
      chk("rand_cout", co, e[32]);
      chk("rand_latency", lat, 5);
    end

    // Single-slice instance
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus1.in0 = 8'hFF; bus1.in1 = 8'hFF; bus1.cin = 1'b1;
      end else begin
        bus1.in0 = 8'($urandom); bus1.in1 = 8'($urandom); bus1.cin = 1'($urandom_range(0, 1));
      end
      e1 = 9'(bus1.in0) + 9'(bus1.in1) + 9'(bus1.cin);
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      @(negedge clk);
      chk("nw1_ready", bus1.in_ready, 1'b1);
      @(posedge clk); #1 bus1.in_valid = 1'b0;
      @(negedge clk);
      chk("nw1_run_valid", bus1.out_valid, 1'b0);
      @(negedge clk);
      chk("nw1_done_valid", bus1.out_valid, 1'b1);
      if (i == 0) begin
        chk("nw1_sum", bus1.sum, 8'hFF);
        chk("nw1_cout", bus1.cout, 1'b1);
      end else begin
        chk("nw1_rand_sum", bus1.sum, e1[7:0]);
        chk("nw1_rand_cout", bus1.cout, e1[8]);
      end
      @(posedge clk); #1 bus1.out_ready = 1'b0;
      @(negedge clk);
      chk("nw1_idle_ready", bus1.in_ready, 1'b1);
      chk("nw1_idle_valid", bus1.out_valid, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_multiword_seq.md
Name: add_multiword_seq

Overview:
- Multi-precision adder sequencer. Accepts two operands of NUM_WORDS*WORD_SIZE bits and adds them one WORD_SIZE slice per cycle through a single internal instance of the `add` module.
- Chains each slice's cout into the next slice's cin. Presents the full-width sum and final carry on a valid/ready output handshake.
- Sits between a requester that needs wide additions and the narrow `add` datapath, trading latency for area.

Parameters:
- WORD_SIZE, 8, width of the shared `add` instance and of one slice.
- NUM_WORDS, 4, number of slices per operand; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and cin are valid.
- in_ready  output  1  block can accept a new operation.
- cin  input  1  carry into slice 0.
- in0  input  NUM_WORDS*WORD_SIZE  operand A; slice k = bits [k*WORD_SIZE +: WORD_SIZE].
- in1  input  NUM_WORDS*WORD_SIZE  operand B, same slicing.
- out_valid  output  1  sum/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  NUM_WORDS*WORD_SIZE  registered full-width sum.
- cout  output  1  registered carry out of the last slice.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, idx=0, carry register=0, sum=0, cout=0, out_valid=0. in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in0, in1; carry<=cin; idx<=0; go to RUN.
  - in_valid while not in IDLE is ignored; operands are not sampled.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the `add` instance gets slice idx of the latched in0/in1 and the carry register.
  - At the edge: sum slice idx <= adder sum; carry <= adder cout; idx <= idx+1.
  - When idx==NUM_WORDS-1: also cout <= adder cout, idx <= 0, go to DONE.
- Latency:
  - Operation accepted at edge E0 → RUN occupies the NUM_WORDS cycles after E0.
  - out_valid=1 starting in cycle NUM_WORDS+1 counting from the acceptance cycle (cycle 0).
  - NUM_WORDS=1 gives exactly one RUN cycle.
- DONE:
  - out_valid=1, in_ready=0. sum and cout are stable for every cycle out_valid is high.
  - On out_ready=1: go to IDLE.
  - out_ready low holds DONE indefinitely (backpressure).
- Throughput: one operation per NUM_WORDS+2 cycles minimum (accept, NUM_WORDS RUN cycles, DONE handshake). No overlap of operations.
- sum/cout keep their last value after the output handshake until overwritten by the next operation's RUN cycles. Consumers sample them only when out_valid=1.
- Arithmetic:
  - Unsigned modulo 2^(NUM_WORDS*WORD_SIZE), with cout = bit NUM_WORDS*WORD_SIZE of in0+in1+cin.
  - Result must equal a single-cycle full-width add bit-for-bit.
- Reset mid-operation (RUN or DONE): rst=1 forces the reset values at the next edge. The partial result is discarded, no out_valid pulse occurs, and the next accepted operation starts clean.
- Simultaneous rst and in_valid: rst wins; the operation is not accepted.
- idx counter width: clog2(NUM_WORDS), minimum 1 bit; it never exceeds NUM_WORDS-1.

Test Plan:
- WORD_SIZE=8, NUM_WORDS=4, in0=0xFFFFFFFF, in1=0x00000001, cin=0, out_ready=1:
  - sum=0x00000000, cout=1.
  - out_valid first high exactly 5 cycles after the acceptance cycle.
  - in_ready low throughout.
- Carry-in across slices: in0=0x12345678, in1=0x11111111, cin=1 → sum=0x2345678A, cout=0.
- Backpressure: in0=0x80000000, in1=0x80000000, cin=0, out_ready held 0 for 10 cycles.
  - out_valid stays 1; sum=0x00000000 and cout=1 stay stable.
  - in_valid pulses with other operands are ignored.
  - Raising out_ready returns to IDLE the next cycle.
- Reset mid-RUN: assert rst for 1 cycle during the 2nd RUN cycle.
  - out_valid never rises; sum=0, cout=0, in_ready=1 after reset.
  - A following 0x00000003+0x00000004, cin=0 yields 0x00000007, cout=0.
- Back-to-back: in_valid held high with 3 queued operand pairs, out_ready=1.
  - Each accepted exactly once, 6 cycles apart.
  - Results match a reference model.
- NUM_WORDS=1, WORD_SIZE=8: in0=0xFF, in1=0xFF, cin=1 → sum=0xFF, cout=1; out_valid 2 cycles after acceptance.
